// File: rtl/swv_pkg.sv
// Shared definitions for the square-wave-voltammetry DAC sequencer:
// default widths, the sequencer state encoding and the DAC saturation helper.
package swv_pkg;

  localparam int SWV_DW  = 16;
  localparam int SWV_HPW = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2,
    ST_FIN  = 2'd3
  } swv_state_e;

  // Clamp a DW+2 bit intermediate sum into the signed DW-bit DAC range.
  function automatic logic signed [SWV_DW-1:0] sat_dw(input logic signed [SWV_DW+1:0] v);
    logic signed [SWV_DW+1:0] max_w;
    logic signed [SWV_DW+1:0] min_w;
    max_w = {3'b000, {(SWV_DW-1){1'b1}}};
    min_w = {3'b111, {(SWV_DW-1){1'b0}}};
    if (v > max_w) begin
      sat_dw = max_w[SWV_DW-1:0];
    end else if (v < min_w) begin
      sat_dw = min_w[SWV_DW-1:0];
    end else begin
      sat_dw = v[SWV_DW-1:0];
    end
  endfunction

endpackage

// File: rtl/swv_half_timer.sv
// Half-period timer: counts 0 .. hp-1 inside one square-wave half and flags
// the last cycle. The counter is reloaded to zero on every half entry and
// held at zero while the sequencer is not inside a half.
module swv_half_timer
  import swv_pkg::*;
#(
  parameter int HPW = SWV_HPW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [HPW-1:0] half_period,
  output logic           tc
);

  localparam logic [HPW-1:0] ONE = {{(HPW-1){1'b0}}, 1'b1};

  logic [HPW-1:0] cnt_r;
  logic [HPW-1:0] hp_eff_s;

  // A programmed half period of zero behaves as a one-cycle half.
  always_comb begin
    if (half_period == '0) begin
      hp_eff_s = ONE;
    end else begin
      hp_eff_s = half_period;
    end
    tc = (cnt_r == (hp_eff_s - ONE));
  end

  // Cycle counter within the current half, restarted on half entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + ONE;
    end
  end

endmodule

// File: rtl/swv_dac_sequencer.sv
// Square-wave-voltammetry potential sequencer. Produces a staircase base
// potential with a superimposed square wave (forward half at base+dir*amp,
// reverse half at base-dir*amp) and strobes the ADC on the last cycle of
// each half. Configuration is captured at scan start.
module swv_dac_sequencer
  import swv_pkg::*;
#(
  parameter int DW  = SWV_DW,
  parameter int HPW = SWV_HPW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic signed [DW-1:0]  e_start,
  input  logic signed [DW-1:0]  e_end,
  input  logic        [DW-1:0]  e_step,
  input  logic        [DW-1:0]  e_amp,
  input  logic signed [DW-1:0]  e_rest,
  input  logic        [HPW-1:0] half_period,
  output logic signed [DW-1:0]  dac_code,
  output logic                  dac_valid,
  output logic                  fwd_sample,
  output logic                  rev_sample,
  output logic        [15:0]    step_idx,
  output logic                  busy,
  output logic                  done
);

  swv_state_e state_r, state_next_s;

  logic signed [DW-1:0] base_r, base_next_s;
  logic signed [DW-1:0] dac_code_r, dac_code_next_s;
  logic signed [DW-1:0] e_end_r, e_rest_r;
  logic        [DW-1:0] e_step_r, e_amp_r;
  logic        [HPW-1:0] hp_r;
  logic                 dir_neg_r;
  logic [15:0]          step_idx_r, step_idx_next_s;
  logic dac_valid_r, dac_valid_next_s;
  logic done_r, done_next_s;
  logic busy_r, busy_next_s;
  logic init_r;
  logic latch_s, timer_load_s, tc_s, enter_fin_s;

  logic signed [DW+1:0] base_w_s, amp_w_s, step_w_s, end_w_s;
  logic signed [DW+1:0] fwd_w_s, rev_w_s, nxt_base_w_s, nxt_fwd_w_s;
  logic signed [DW+1:0] st_base_w_s, st_amp_w_s, st_fwd_w_s;
  logic                 dir_neg_in_s, past_end_s;

  swv_half_timer #(.HPW(HPW)) u_half_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (timer_load_s),
    .half_period (hp_r),
    .tc          (tc_s)
  );

  // Potential arithmetic in DW+2 bits so sums never wrap before saturation.
  always_comb begin
    base_w_s     = {{2{base_r[DW-1]}}, base_r};
    amp_w_s      = {2'b00, e_amp_r};
    step_w_s     = {2'b00, e_step_r};
    end_w_s      = {{2{e_end_r[DW-1]}}, e_end_r};
    fwd_w_s      = dir_neg_r ? (base_w_s - amp_w_s) : (base_w_s + amp_w_s);
    rev_w_s      = dir_neg_r ? (base_w_s + amp_w_s) : (base_w_s - amp_w_s);
    nxt_base_w_s = dir_neg_r ? (base_w_s - step_w_s) : (base_w_s + step_w_s);
    nxt_fwd_w_s  = dir_neg_r ? (nxt_base_w_s - amp_w_s) : (nxt_base_w_s + amp_w_s);
    past_end_s   = dir_neg_r ? (nxt_base_w_s < end_w_s) : (nxt_base_w_s > end_w_s);
    dir_neg_in_s = (e_end < e_start);
    st_base_w_s  = {{2{e_start[DW-1]}}, e_start};
    st_amp_w_s   = {2'b00, e_amp};
    st_fwd_w_s   = dir_neg_in_s ? (st_base_w_s - st_amp_w_s) : (st_base_w_s + st_amp_w_s);
  end

  // Next-state and next-output logic for the scan sequencer.
  always_comb begin
    state_next_s     = state_r;
    base_next_s      = base_r;
    step_idx_next_s  = step_idx_r;
    dac_code_next_s  = dac_code_r;
    dac_valid_next_s = 1'b0;
    done_next_s      = 1'b0;
    busy_next_s      = busy_r;
    latch_s          = 1'b0;
    timer_load_s     = 1'b1;
    enter_fin_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          latch_s          = 1'b1;
          state_next_s     = ST_FWD;
          base_next_s      = e_start;
          step_idx_next_s  = 16'd0;
          dac_code_next_s  = sat_dw(st_fwd_w_s);
          dac_valid_next_s = 1'b1;
          busy_next_s      = 1'b1;
        end else if (init_r || (e_rest != dac_code_r)) begin
          // Rest potential is (re)loaded after reset or when it is reprogrammed.
          dac_code_next_s  = e_rest;
          dac_valid_next_s = 1'b1;
        end else begin
          dac_valid_next_s = 1'b0;
        end
      end
      ST_FWD: begin
        if (abort) begin
          enter_fin_s = 1'b1;
        end else if (tc_s) begin
          state_next_s     = ST_REV;
          dac_code_next_s  = sat_dw(rev_w_s);
          dac_valid_next_s = 1'b1;
        end else begin
          timer_load_s = 1'b0;
        end
      end
      ST_REV: begin
        if (abort) begin
          enter_fin_s = 1'b1;
        end else if (tc_s) begin
          if (past_end_s || (e_step_r == '0)) begin
            enter_fin_s = 1'b1;
          end else begin
            state_next_s     = ST_FWD;
            base_next_s      = nxt_base_w_s[DW-1:0];
            step_idx_next_s  = step_idx_r + 16'd1;
            dac_code_next_s  = sat_dw(nxt_fwd_w_s);
            dac_valid_next_s = 1'b1;
          end
        end else begin
          timer_load_s = 1'b0;
        end
      end
      ST_FIN: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    // Common scan termination: return to rest and report completion.
    if (enter_fin_s) begin
      state_next_s     = ST_FIN;
      dac_code_next_s  = e_rest_r;
      dac_valid_next_s = 1'b1;
      done_next_s      = 1'b1;
      busy_next_s      = 1'b0;
    end else begin
      done_next_s = 1'b0;
    end
  end

  // State and registered output update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      base_r      <= '0;
      step_idx_r  <= 16'd0;
      dac_code_r  <= '0;
      dac_valid_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      init_r      <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      base_r      <= base_next_s;
      step_idx_r  <= step_idx_next_s;
      dac_code_r  <= dac_code_next_s;
      dac_valid_r <= dac_valid_next_s;
      done_r      <= done_next_s;
      busy_r      <= busy_next_s;
      init_r      <= 1'b0;
    end
  end

  // Scan configuration captured at start so mid-scan input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_end_r   <= '0;
      e_rest_r  <= '0;
      e_step_r  <= '0;
      e_amp_r   <= '0;
      hp_r      <= '0;
      dir_neg_r <= 1'b0;
    end else if (latch_s) begin
      e_end_r   <= e_end;
      e_rest_r  <= e_rest;
      e_step_r  <= e_step;
      e_amp_r   <= e_amp;
      hp_r      <= half_period;
      dir_neg_r <= dir_neg_in_s;
    end else begin
      dir_neg_r <= dir_neg_r;
    end
  end

  assign dac_code   = dac_code_r;
  assign dac_valid  = dac_valid_r;
  assign done       = done_r;
  assign busy       = busy_r;
  assign step_idx   = step_idx_r;
  assign fwd_sample = (state_r == ST_FWD) && tc_s;
  assign rev_sample = (state_r == ST_REV) && tc_s;

endmodule

// File: tb/tb_swv_dac_sequencer.sv
// Self-checking bench for swv_dac_sequencer. Expected waveforms come from a
// closed-form model: cycle k of a scan lies in step (k-1)/(2hp), half
// ((k-1)/hp) mod 2, at position (k-1) mod hp.
module tb_swv_dac_sequencer;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic signed [15:0] e_start, e_end, e_rest;
  logic [15:0] e_step, e_amp;
  logic [23:0] half_period;
  logic signed [15:0] dac_code;
  logic dac_valid, fwd_sample, rev_sample, busy, done;
  logic [15:0] step_idx;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  swv_dac_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .e_start(e_start), .e_end(e_end), .e_step(e_step), .e_amp(e_amp),
    .e_rest(e_rest), .half_period(half_period),
    .dac_code(dac_code), .dac_valid(dac_valid), .fwd_sample(fwd_sample),
    .rev_sample(rev_sample), .step_idx(step_idx), .busy(busy), .done(done)
  );

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return v;
  endfunction

  // Runs one scan from IDLE (called at a falling edge) and checks every cycle
  // through FIN and one IDLE cycle. abort_at>0 aborts after observed cycle k.
  task automatic run_scan(input string name, input int es, input int ee, input int stp,
                          input int amp, input int hp, input int rest, input int abort_at);
    int dir, n, hpe, f, kend, d, s, h, pos, base, ecode, nf, nr, last_s;
    logic ev, ef, er, eb, ed;
    logic [36:0] obs, exp_v;
    hpe  = (hp == 0) ? 1 : hp;
    dir  = (ee >= es) ? 1 : -1;
    d    = ee - es;
    if (d < 0) d = -d;
    n    = (stp == 0) ? 1 : (d / stp + 1);
    f    = 2 * hpe * n;
    kend = (abort_at > 0 && abort_at < f) ? abort_at : f;
    e_start = 16'(es); e_end = 16'(ee); e_step = 16'(stp); e_amp = 16'(amp);
    e_rest = 16'(rest); half_period = 24'(hp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nf = 0; nr = 0; last_s = 0; s = 0;
    for (int k = 1; k <= kend + 2; k++) begin
      if (k <= kend) begin
        s   = (k - 1) / (2 * hpe);
        h   = ((k - 1) / hpe) % 2;
        pos = (k - 1) % hpe;
        base  = es + dir * s * stp;
        ecode = sat16((h == 0) ? (base + dir * amp) : (base - dir * amp));
        ev = (pos == 0); ef = (h == 0) && (pos == hpe - 1); er = (h == 1) && (pos == hpe - 1);
        eb = 1'b1; ed = 1'b0; last_s = s;
      end else begin
        ecode = rest; ev = (k == kend + 1); ef = 1'b0; er = 1'b0;
        eb = 1'b0; ed = (k == kend + 1); s = last_s;
      end
      exp_v = {16'(ecode), ev, ef, er, eb, ed, 16'(s)};
      obs   = {dac_code, dac_valid, fwd_sample, rev_sample, busy, done, step_idx};
      n_checks++;
      if (obs !== exp_v) begin
        n_fails++;
        $display("FAIL %s k=%0d: got code=%0d valid=%b fwd=%b rev=%b busy=%b done=%b step=%0d; expected code=%0d valid=%b fwd=%b rev=%b busy=%b done=%b step=%0d",
                 name, k, dac_code, dac_valid, fwd_sample, rev_sample, busy, done, step_idx,
                 ecode, ev, ef, er, eb, ed, s);
      end
      nf += int'(fwd_sample);
      nr += int'(rev_sample);
      abort = (k == kend) && (kend < f);
      start = abort;  // a start alongside abort must be ignored
      if (k < kend) begin
        e_start = 16'($urandom); e_end = 16'($urandom); e_step = 16'($urandom);
        e_amp = 16'($urandom); e_rest = 16'($urandom); half_period = 24'($urandom);
      end else begin
        e_rest = 16'(rest);
      end
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
    if (kend == f) begin
      n_checks++;
      if (nf != n || nr != n) begin
        n_fails++;
        $display("FAIL %s strobe_count: got fwd=%0d rev=%0d, expected %0d each", name, nf, nr, n);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    e_start = 16'sd0; e_end = 16'sd0; e_step = 16'd0; e_amp = 16'd0;
    e_rest = 16'sd50; half_period = 24'd1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({dac_code, dac_valid, fwd_sample, rev_sample, busy, done, step_idx} !== 37'd0) begin
      n_fails++;
      $display("FAIL reset_values: got code=%0d valid=%b fwd=%b rev=%b busy=%b done=%b step=%0d, expected all 0",
               dac_code, dac_valid, fwd_sample, rev_sample, busy, done, step_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dac_code !== 16'sd50 || dac_valid !== 1'b1 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_rest_load: got code=%0d valid=%b busy=%b, expected code=50 valid=1 busy=0",
               dac_code, dac_valid, busy);
    end
    @(negedge clk);
    n_checks++;
    if (dac_code !== 16'sd50 || dac_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL idle_hold: got code=%0d valid=%b, expected code=50 valid=0", dac_code, dac_valid);
    end
  endtask

  task automatic test_nominal;
    run_scan("nominal", -600, -100, 4, 25, 4, -200, 0);
  endtask

  task automatic test_negative;
    run_scan("negative", -100, -600, 4, 25, 4, -200, 0);
  endtask

  task automatic test_abort;
    run_scan("abort_rev_step10", -600, -100, 4, 25, 4, 75, 86);
    run_scan("abort_fwd_first", 100, 400, 10, 30, 3, 75, 1);
  endtask

  task automatic test_saturation;
    run_scan("sat_high", 32760, 32767, 0, 25, 2, 0, 0);
    run_scan("sat_low", -32760, -32768, 3, 40, 1, 0, 0);
  endtask

  task automatic test_edge_hp;
    run_scan("hp0", 0, 20, 5, 10, 0, 7, 0);
    run_scan("hp1", 20, 0, 5, 10, 1, 7, 0);
  endtask

  task automatic test_idle_abort_start;
    e_start = 16'sd0; e_end = 16'sd100; e_step = 16'd10; e_amp = 16'd5; half_period = 24'd2;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || dac_valid !== 1'b0 || done !== 1'b0 || dac_code !== e_rest) begin
      n_fails++;
      $display("FAIL idle_abort_start: got busy=%b valid=%b done=%b code=%0d, expected busy=0 valid=0 done=0 code=%0d",
               busy, dac_valid, done, dac_code, e_rest);
    end
  endtask

  task automatic test_reset_mid;
    e_start = -16'sd600; e_end = -16'sd100; e_step = 16'd4; e_amp = 16'd25;
    e_rest = 16'sd33; half_period = 24'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({dac_code, dac_valid, fwd_sample, rev_sample, busy, done, step_idx} !== 37'd0) begin
      n_fails++;
      $display("FAIL reset_mid_values: got code=%0d valid=%b fwd=%b rev=%b busy=%b done=%b step=%0d, expected all 0",
               dac_code, dac_valid, fwd_sample, rev_sample, busy, done, step_idx);
    end
    @(negedge clk);
    n_checks++;
    if (dac_code !== 16'sd33 || dac_valid !== 1'b1 || busy !== 1'b0 || fwd_sample !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_mid_rest: got code=%0d valid=%b busy=%b fwd=%b, expected code=33 valid=1 busy=0 fwd=0",
               dac_code, dac_valid, busy, fwd_sample);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int es, ee, stp, amp, hp, rest, ab;
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) begin
        es = 32767 - int'($urandom_range(0, 60));
        if (i % 2 == 0) es = -es;
        ee = (es > 0) ? es - int'($urandom_range(0, 300)) : es + int'($urandom_range(0, 300));
        amp = int'($urandom_range(0, 4000));
      end else begin
        es  = int'($urandom_range(0, 1600)) - 800;
        ee  = int'($urandom_range(0, 1600)) - 800;
        amp = int'($urandom_range(0, 65535));
      end
      stp  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(4, 40));
      hp   = int'($urandom_range(0, 3));
      rest = int'($urandom_range(0, 2000)) - 1000;
      ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : 0;
      run_scan("random", es, ee, stp, amp, hp, rest, ab);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_negative();
    test_abort();
    test_saturation();
    test_edge_hp();
    test_idle_abort_start();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/swv_dac_sequencer.md
# swv_dac_sequencer

Digital square-wave-voltammetry (SWV) potential sequencer that generates the staircase-plus-square-wave DAC code driving the working-electrode potential across the electron-transfer cell model. Forward and reverse sample strobes are timed to the end of each half-period for the downstream current ADC. It sits directly upstream of the cell: its DAC output sets V(p,n), and the cell returns the faradaic and non-faradaic current.

## Interface
- DW, 16: signed DAC code width; 1 LSB = 1 mV at the cell.
- HPW, 24: half-period counter width, in clock cycles.
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  one-cycle pulse; begins a scan when idle.
- abort  in  1  one-cycle pulse; ends the scan immediately.
- e_start  in  DW signed  first staircase base potential.
- e_end  in  DW signed  last permitted base potential.
- e_step  in  DW unsigned  staircase increment magnitude.
- e_amp  in  DW unsigned  square-wave amplitude.
- e_rest  in  DW signed  potential held outside a scan.
- half_period  in  HPW  cycles per half-wave; 0 is treated as 1.
- dac_code  out  DW signed  registered potential code.
- dac_valid  out  1  one-cycle pulse on every dac_code update.
- fwd_sample  out  1  pulse on the last cycle of each forward half.
- rev_sample  out  1  pulse on the last cycle of each reverse half.
- step_idx  out  16  index of the current staircase step, starting at 0.
- busy  out  1  high from the cycle after start until done or abort.
- done  out  1  one-cycle pulse when a scan completes normally or is aborted.

## Operation
- States:
  - IDLE: dac_code = e_rest.
  - FWD
  - REV
  - FIN
- Starting a scan: start in IDLE latches all config inputs. dir = +1 if e_end >= e_start, else -1. base = e_start, step_idx = 0. The next state is FWD.
- Code values:
  - FWD: dac_code = clamp(base + dir*e_amp).
  - REV: dac_code = clamp(base - dir*e_amp).
- Arithmetic: all sums are computed in DW+2 bits, then saturated to the signed DW range.
- End of REV: next_base = base + dir*e_step.
  - If next_base passes e_end (beyond it in the dir sense), or e_step = 0, go to FIN.
  - Otherwise set base = next_base, increment step_idx, and go to FWD.
- Step count: N = floor(|e_end - e_start| / e_step) + 1, or N = 1 when e_step = 0.
- FIN: set dac_code = e_rest, pulse dac_valid and done, clear busy, then go to IDLE.
- Abort in FWD or REV: go to FIN on the next cycle. No further sample strobes are issued.
- Ignored inputs:
  - start outside IDLE.
  - abort in IDLE or FIN.
- Simultaneous events:
  - abort and start in the same cycle: abort wins; a start in IDLE is then ignored.
  - abort on the last cycle of REV: the sample strobe for that cycle still fires, and the next state is FIN.
- Config inputs may change during a scan without effect.

## Timing
- Reset values (rst_n low at a clk edge):
  - dac_code = 0.
  - All pulses = 0.
  - busy = 0, step_idx = 0.
  - State = IDLE.
  - The first cycle after reset loads e_rest into dac_code and pulses dac_valid.
- Start latency: start at cycle t gives state FWD, busy = 1, the new dac_code and dac_valid at t+1.
- Half-period timer:
  - Counts 0 .. hp-1 within each half.
  - The sample strobe is asserted combinationally from registered state while cnt = hp-1.
  - The state flips at the following edge.
  - With hp = 1, every cycle alternates halves and every cycle carries a strobe.
- Each staircase step spans exactly 2*hp cycles. A full scan is 2*hp*N cycles in FWD/REV plus 1 FIN cycle.
- dac_valid pulses on each change of half, coincident with the new dac_code. It does not pulse on cycles where the code is held.

## Structure
- Shared package swv_pkg contains:
  - The state enum (IDLE, FWD, REV, FIN).
  - The DW/HPW defaults.
  - A saturate-to-DW function.
- Sub-module swv_half_timer contains:
  - The HPW counter with load on half entry.
  - The zero-to-one half_period mapping.
  - The terminal-count output.

## Test plan
- Nominal scan: e_start=-600, e_end=-100, e_step=4, e_amp=25, hp=4.
  - Codes follow -575, -625, -571, -621, ….
  - 126 steps and 126 fwd/rev strobe pairs.
  - done at cycle 1009 after start.
  - dac_code ends at e_rest.
- Negative scan: e_start=-100, e_end=-600, same settings.
  - First codes are -125 then -75.
  - The final base is -600.
- Abort mid-REV of step 10 → FIN next cycle, done pulse, step_idx=10, no further strobes. Simultaneous start is ignored.
- Saturation: e_start=32760, e_amp=25, e_end=32767, e_step=0 → FWD code 32767, REV code 32735, N=1.
- Edge timing: hp=0 and hp=1 → a one-cycle half each, with a strobe every cycle.
- Reset mid-FWD → all outputs at reset values the next cycle, and the following cycle loads e_rest.
